dti_rr_arbiter: RTL and testbench
=================================

# dti_rr_arbiter

Round-robin arbiter that shares one DTI output channel, for example the input of a decoupler FIFO, between NUM requesting DTI producers. Each cycle it selects one valid requester and forwards its beat through a single registered output stage, tagged with the requester index. Optional transaction locking keeps a multi-beat transaction from one requester contiguous on the shared channel. It sits between several independent producers and a single shared consumer or buffer.

## Interface
Parameters:
- NUM, 4: number of requesters; legal range 2..16.
- DIN, 16: data width per requester. When locking is enabled, bit DIN-1 is the end-of-transaction (eot) flag.
- IDX_W: localparam, $clog2(NUM); width of the index tag.

Ports:
- clk, input, 1: clock; all state changes on its rising edge.
- rst, input, 1: asynchronous, active-low reset. Asserting it (low) clears all state immediately.
- din_data, input, NUM*DIN: requester data; requester i occupies bits [i*DIN +: DIN].
- din_valid, input, NUM: per-requester valid.
- din_ready, output, NUM: per-requester ready; at most one bit is set in any cycle.
- dout, dti.producer, DIN+IDX_W: data = {idx, data}, where idx is the source requester; carries valid and ready.

## Operation
- Output register: out_valid, out_data, out_idx. dout.valid = out_valid.
- accept = !out_valid || dout.ready. The register loads whenever accept is high and any eligible requester is valid.
- Grant (combinational):
  - Search requesters starting at ptr, wrapping NUM-1 -> 0.
  - Grant the first requester with din_valid set.
  - din_ready[g] = accept && din_valid[g] for the granted g. All other bits are 0.
- Transfer on requester g: the register loads {g, din_data[g]}; ptr <= (g+1) mod NUM. For non-power-of-two NUM, ptr wraps explicitly.
- When accept is high and no requester is valid: out_valid <= 0. Data may hold.
- When accept is low: the register holds and all din_ready bits are 0.
- Fairness: with all NUM requesters continuously valid and dout.ready held high, grants rotate 0,1,..,NUM-1,0,...
- Rules:
  - din_valid must not depend on din_ready.
  - A requester may drop valid without a transfer. The arbiter holds no grant state for it except a lock (see Configuration).

## Timing
- Reset values: dout.valid=0, dout.data=0, din_ready=0 while in reset, ptr=0, lock=0.
- Latency: a requester beat appears on dout the cycle after its transfer.
- Throughput: 1 beat/cycle when dout.ready is held high.
- Simultaneous events in one cycle: the output transfer (dout.valid && dout.ready) and the next input load both happen.
- Backpressure: with dout.ready=0 and out_valid=1, dout.data and dout.valid stay stable until the output transfer completes.
- Combinational paths:
  - dout.ready -> din_ready exists.
  - No combinational path from any input to dout.valid or dout.data.
- Reset mid-operation: the in-flight output beat is discarded, dout.valid drops asynchronously, and ptr and lock clear.

## Configuration
- Macro: DTI_RR_ARBITER_LOCK_EN.
- Defined:
  - Registers lock (1 bit) and lock_idx (IDX_W bits).
  - Transfer from g with din_data[g][DIN-1]==0 and lock=0: lock<=1, lock_idx<=g.
  - While lock=1, only lock_idx is eligible; other requesters get din_ready=0 even if lock_idx is idle.
  - A transfer from lock_idx with eot=1 clears lock. ptr advances only on eot transfers.
  - A transfer with eot=1 while unlocked: a single-beat transaction, no lock.
- Undefined:
  - No lock logic. Arbitration happens every beat and bit DIN-1 is plain data.

## Test plan
- Reset and idle: hold rst low, then release with all din_valid=0 -> dout.valid=0, din_ready=0, dout.data=0 throughout.
- Full rotation: NUM=4, all din_valid=1, din_i data = 0x0010+i, dout.ready=1 -> dout shows idx 0,1,2,3,0 with matching data on consecutive cycles, and each beat lags its din_ready pulse by 1 cycle.
- Backpressure: dout.ready=0 for 5 cycles with requesters 1 and 2 valid -> dout holds {1, data1} stable and din_ready=0. When ready rises, {1, data1} transfers and requester 2 is granted in that same cycle.
- Sparse and wrap: only requester 3 valid, then only requester 0 -> grants 3 then 0, ptr wraps to 1. Repeat with NUM=3 and confirm idx never reaches 3.
- Lock (macro defined): requester 1 sends 3 beats with eot=0,0,1 while requester 2 stays valid -> dout idx sequence 1,1,1,2. Without the macro the same stimulus yields 1,2,1,2,...
- Reset mid-operation: assert rst while out_valid=1 and lock=1 -> dout.valid drops immediately. After release, requester 0 is granted first and the lock is clear.

Source files
------------

// File: rtl/dti_rr_arbiter.sv
// dti_rr_arbiter: round-robin arbiter sharing one registered DTI output among
// NUM producers. Each output beat is tagged with the index of its source.
// Defining DTI_RR_ARBITER_LOCK_EN enables transaction locking. In that build,
// bit DIN-1 of a beat is the end-of-transaction flag, and a multi-beat
// transaction from one requester stays contiguous on the output.
module dti_rr_arbiter #(
   parameter  int unsigned NUM   = 4,
   parameter  int unsigned DIN   = 16,
   localparam int unsigned IDX_W = $clog2(NUM)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM*DIN-1:0]   din_data,
   input  logic [NUM-1:0]       din_valid,
   output logic [NUM-1:0]       din_ready,
   output logic [DIN+IDX_W-1:0] dout_data,
   output logic                 dout_valid,
   input  logic                 dout_ready
);

   logic             out_valid_q, out_valid_d;
   logic [DIN-1:0]   out_data_q, out_data_d;
   logic [IDX_W-1:0] out_idx_q, out_idx_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [NUM-1:0]   elig;
   logic             accept;
   logic             xfer;
   logic             gnt_found;
   logic [IDX_W-1:0] gnt_idx;
   logic [IDX_W-1:0] gnt_next;
   logic [DIN-1:0]   gnt_data;

   assign accept     = !out_valid_q || dout_ready;
   assign xfer       = accept && gnt_found;
   assign dout_valid = out_valid_q;
   assign dout_data  = {out_idx_q, out_data_q};
   assign gnt_next   = (gnt_idx == IDX_W'(NUM - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef DTI_RR_ARBITER_LOCK_EN
   logic             lock_q, lock_d;
   logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

   // While a transaction is locked, only its owner may be granted.
   always_comb begin
      elig = din_valid;
      if (lock_q) begin
         elig             = '0;
         elig[lock_idx_q] = din_valid[lock_idx_q];
      end
   end
`else
   assign elig = din_valid;
`endif

   // Search from ptr upward, wrapping at NUM-1, for the first eligible requester.
   always_comb begin : grant_search
      int unsigned      cand;
      logic [IDX_W-1:0] ci;
      cand      = 0;
      ci        = '0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      gnt_data  = '0;
      for (int unsigned k = 0; k < NUM; k++) begin
         cand = int'(ptr_q) + k;
         if (cand >= NUM) cand = cand - NUM;
         ci = IDX_W'(cand);
         if (!gnt_found && elig[ci]) begin
            gnt_found = 1'b1;
            gnt_idx   = ci;
            gnt_data  = din_data[ci*DIN +: DIN];
         end
      end
   end

   // One-hot ready to the granted requester; held low while reset is asserted.
   always_comb begin
      din_ready = '0;
      if (xfer && rst) din_ready[gnt_idx] = 1'b1;
   end

   // Next state of the output register, the round-robin pointer and the lock.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      ptr_d       = ptr_q;
`ifdef DTI_RR_ARBITER_LOCK_EN
      lock_d      = lock_q;
      lock_idx_d  = lock_idx_q;
`endif
      if (accept) begin
         out_valid_d = gnt_found;
         if (gnt_found) begin
            out_data_d = gnt_data;
            out_idx_d  = gnt_idx;
`ifdef DTI_RR_ARBITER_LOCK_EN
            // The pointer only moves past a requester once its transaction ends.
            if (gnt_data[DIN-1]) begin
               ptr_d  = gnt_next;
               lock_d = 1'b0;
            end else if (!lock_q) begin
               lock_d     = 1'b1;
               lock_idx_d = gnt_idx;
            end
`else
            ptr_d = gnt_next;
`endif
         end
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         ptr_q       <= '0;
`ifdef DTI_RR_ARBITER_LOCK_EN
         lock_q      <= 1'b0;
         lock_idx_q  <= '0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         ptr_q       <= ptr_d;
`ifdef DTI_RR_ARBITER_LOCK_EN
         lock_q      <= lock_d;
         lock_idx_q  <= lock_idx_d;
`endif
      end
   end

endmodule

// File: tb/tb_dti_rr_arbiter.sv
// Scoreboard bench for dti_rr_arbiter: a NUM=4 and a NUM=3 instance. Stimulus
// pushes hand-computed expected beats; per-instance monitors pop on output transfers.
module tb_dti_rr_arbiter;

`ifdef DTI_RR_ARBITER_LOCK_EN
   localparam logic [15:0] EOT = 16'h8000;
`else
   localparam logic [15:0] EOT = 16'h0000;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] d4_data;
   logic [3:0]  d4_valid, d4_ready;
   logic [17:0] o4_data;
   logic        o4_valid, o4_ready;
   logic [47:0] d3_data;
   logic [2:0]  d3_valid, d3_ready;
   logic [17:0] o3_data;
   logic        o3_valid, o3_ready;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      logic [17:0] data;
      int          cyc;
   } exp_t;
   exp_t q4[$];
   exp_t q3[$];
   exp_t e4, e3;

   logic [3:0]  lk_v  [5];
   logic [15:0] lk_d1 [5];
   logic [3:0]  lk_r  [5];
   int          lk_pi [5];
   logic [15:0] lk_pd [5];
   int          n3_idx[5];
   logic [2:0]  n3_v  [5];

   dti_rr_arbiter #(.NUM(4), .DIN(16)) u4 (
      .clk(clk), .rst(rst), .din_data(d4_data), .din_valid(d4_valid), .din_ready(d4_ready),
      .dout_data(o4_data), .dout_valid(o4_valid), .dout_ready(o4_ready));

   dti_rr_arbiter #(.NUM(3), .DIN(16)) u3 (
      .clk(clk), .rst(rst), .din_data(d3_data), .din_valid(d3_valid), .din_ready(d3_ready),
      .dout_data(o3_data), .dout_valid(o3_valid), .dout_ready(o3_ready));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [17:0] beat(input int idx, input logic [15:0] d);
      logic [1:0] i2;
      i2 = 2'(idx);
      return {i2, d};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set4(input int i, input logic [15:0] v);
      d4_data[i*16 +: 16] = v;
   endtask

   // Monitor for the NUM=4 instance.
   always @(negedge clk) begin
      if (o4_valid && o4_ready) begin
         if (q4.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL u4_extra_beat: got %0h expected no beat", o4_data);
         end else begin
            e4 = q4.pop_front();
            check("u4_beat", o4_data, e4.data);
            if (e4.cyc != 0) check("u4_latency", cyc, e4.cyc);
         end
      end
   end

   // Monitor for the NUM=3 instance.
   always @(negedge clk) begin
      if (o3_valid && o3_ready) begin
         check("n3_idx_range", o3_data[17:16] < 2'd3, 1);
         if (q3.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL n3_extra_beat: got %0h expected no beat", o3_data);
         end else begin
            e3 = q3.pop_front();
            check("n3_beat", o3_data, e3.data);
            if (e3.cyc != 0) check("n3_latency", cyc, e3.cyc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
`ifdef DTI_RR_ARBITER_LOCK_EN
      lk_v  = '{4'b0110, 4'b0100, 4'b0110, 4'b0110, 4'b0100};
      lk_d1 = '{16'h0A01, 16'h0B01, 16'h0B01, 16'h8C01, 16'h8C01};
      lk_r  = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0100};
      lk_pi = '{1, -1, 1, 1, 2};
      lk_pd = '{16'h0A01, 16'h0000, 16'h0B01, 16'h8C01, 16'h8022};
`else
      lk_v  = '{4'b0110, 4'b0100, 4'b0110, 4'b0110, 4'b0110};
      lk_d1 = '{16'h0A01, 16'h0B01, 16'h0B01, 16'h8C01, 16'h8C01};
      lk_r  = '{4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0010};
      lk_pi = '{1, 2, 1, 2, 1};
      lk_pd = '{16'h0A01, 16'h8022, 16'h0B01, 16'h8022, 16'h8C01};
`endif
      n3_v   = '{3'b100, 3'b001, 3'b111, 3'b111, 3'b111};
      n3_idx = '{2, 0, 1, 2, 0};

      rst = 1'b0;
      d4_valid = '0; d4_data = '0; o4_ready = 1'b1;
      d3_valid = '0; d3_data = '0; o3_ready = 1'b1;

      // Reset and idle
      repeat (2) tick();
      d4_valid = 4'hF;
      #1;
      check("rst_din_ready", d4_ready, 0);
      check("rst_dout_valid", o4_valid, 0);
      check("rst_dout_data", o4_data, 0);
      d4_valid = '0;
      tick();
      rst = 1'b1;
      repeat (3) begin
         tick();
         check("idle_dout_valid", o4_valid, 0);
         check("idle_dout_data", o4_data, 0);
         check("idle_din_ready", d4_ready, 0);
      end

      // Full rotation 0,1,2,3,0
      for (int i = 0; i < 4; i++) set4(i, EOT | 16'(16'h0010 + i));
      d4_valid = 4'hF;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("rot_grant", d4_ready, 4'b0001 << (k % 4));
         q4.push_back('{beat(k % 4, EOT | 16'(16'h0010 + k % 4)), cyc + 1});
         tick();
      end
      d4_valid = '0;
      tick();

      // Backpressure: requester 1 held, then 2 granted as 1 leaves
      o4_ready = 1'b0;
      d4_valid = 4'b0110;
      #1;
      check("bp_grant1", d4_ready, 4'b0010);
      q4.push_back('{beat(1, EOT | 16'h0011), 0});
      for (int k = 0; k < 5; k++) begin
         tick();
         #1;
         check("bp_hold_data", o4_data, beat(1, EOT | 16'h0011));
         check("bp_hold_valid", o4_valid, 1);
         check("bp_ready_low", d4_ready, 0);
      end
      tick();
      o4_ready = 1'b1;
      #1;
      check("bp_grant2", d4_ready, 4'b0100);
      q4.push_back('{beat(2, EOT | 16'h0012), cyc + 1});
      tick();
      d4_valid = '0;
      tick();

      // Sparse requests and pointer wrap
      d4_valid = 4'b1000;
      #1;
      check("wrap_g3", d4_ready, 4'b1000);
      q4.push_back('{beat(3, EOT | 16'h0013), cyc + 1});
      tick();
      d4_valid = 4'b0001;
      #1;
      check("wrap_g0", d4_ready, 4'b0001);
      q4.push_back('{beat(0, EOT | 16'h0010), cyc + 1});
      tick();
      d4_valid = 4'hF;
      #1;
      check("wrap_ptr1", d4_ready, 4'b0010);
      q4.push_back('{beat(1, EOT | 16'h0011), cyc + 1});
      tick();
      d4_valid = 4'b0001;
      #1;
      check("wrap_g0b", d4_ready, 4'b0001);
      q4.push_back('{beat(0, EOT | 16'h0010), cyc + 1});
      tick();
      d4_valid = '0;
      tick();

      // Locked multi-beat transaction from requester 1, requester 2 competing
      for (int s = 0; s < 5; s++) begin
         d4_valid = lk_v[s];
         set4(1, lk_d1[s]);
         set4(2, 16'h8022);
         #1;
         check("lock_grant", d4_ready, lk_r[s]);
         if (lk_pi[s] >= 0) q4.push_back('{beat(lk_pi[s], lk_pd[s]), cyc + 1});
         tick();
      end
      d4_valid = '0;
      tick();

      // Reset while a beat is held (and, with locking, a lock is open)
      o4_ready = 1'b0;
      d4_valid = 4'b0010;
      set4(1, 16'h0A01);
      #1;
      check("mid_grant", d4_ready, 4'b0010);
      tick();
      d4_valid = '0;
      #1;
      check("mid_out_valid", o4_valid, 1);
      #1;
      rst = 1'b0;
      #1;
      check("mid_rst_valid", o4_valid, 0);
      check("mid_rst_data", o4_data, 0);
      tick();
      tick();
      rst = 1'b1;
      o4_ready = 1'b1;
      set4(1, EOT | 16'h0011);
      d4_valid = 4'hF;
      #1;
      check("post_rst_g0", d4_ready, 4'b0001);
      q4.push_back('{beat(0, EOT | 16'h0010), cyc + 1});
      tick();
      #1;
      check("post_rst_g1", d4_ready, 4'b0010);
      q4.push_back('{beat(1, EOT | 16'h0011), cyc + 1});
      tick();
      d4_valid = '0;
      tick();

      // NUM=3: wrap from 2 to 0, then rotate without ever reaching index 3
      for (int i = 0; i < 3; i++) d3_data[i*16 +: 16] = 16'(16'h8030 + i);
      for (int s = 0; s < 5; s++) begin
         d3_valid = n3_v[s];
         #1;
         check("n3_grant", d3_ready, 3'b001 << n3_idx[s]);
         q3.push_back('{beat(n3_idx[s], 16'(16'h8030 + n3_idx[s])), cyc + 1});
         tick();
      end
      d3_valid = '0;

      repeat (3) tick();
      check("q4_drained", q4.size(), 0);
      check("q3_drained", q3.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
